// File: rtl/riscv_lsu_pkg.sv
//------------------------------------------------------------------------------
// riscv_lsu_pkg
// Shared definitions for the RISC-V load/store unit: funct3 size encodings,
// the controller state type and an access-width decode helper.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_lsu_pkg;

  // funct3 load/store size encodings
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } lsu_width_t;

  // Undefined encodings (3, 6, 7) fall through to a full word.
  function automatic lsu_width_t size_width(input logic [2:0] size);
    case (size)
      LDST_B, LDST_BU: size_width = WIDTH_BYTE;
      LDST_H, LDST_HU: size_width = WIDTH_HALF;
      default:         size_width = WIDTH_WORD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_lsu_load_align.sv
//------------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data extraction and extension.
// Ports:
//   mem_rd_i  [31:0] raw memory word
//   addr      [1:0]  low byte address bits of the access
//   size      [2:0]  funct3 size encoding
//   data      [31:0] extracted, sign/zero-extended load result
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] mem_rd_i,
  input  logic [1:0]  addr,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = mem_rd_i[7:0];
      2'd1:    byte_sel = mem_rd_i[15:8];
      2'd2:    byte_sel = mem_rd_i[23:16];
      default: byte_sel = mem_rd_i[31:24];
    endcase
    half_sel = addr[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
  end

  always_comb begin
    case (size)
      LDST_B:  data = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data = {24'd0, byte_sel};
      LDST_H:  data = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data = {16'd0, half_sel};
      default: data = mem_rd_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_lsu.sv
//------------------------------------------------------------------------------
// riscv_lsu
// Three-state load/store unit between a RISC-V core and a word memory.
// Ports:
//   clk_i, rst_i (async, active-high)
//   core_req_i/core_we_i/core_size_i/core_addr_i/core_wd_i : core request
//   core_rd_o/core_stall_o/core_misalign_o                  : core response
//   mem_req_o/mem_we_o/mem_be_o/mem_addr_o/mem_wd_o         : memory request
//   mem_rd_i/mem_ready_i                                    : memory response
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W
// accesses instead of silently ignoring the offending address bits.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  state, state_next;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic        mis_q;
  logic        req_misaligned;
  logic [3:0]  be;
  logic [31:0] wd_rep;
  logic [31:0] load_data;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_misaligned = 1'b0;
    case (size_width(core_size_i))
      WIDTH_HALF: req_misaligned = core_addr_i[0];
      WIDTH_WORD: req_misaligned = |core_addr_i[1:0];
      default:    req_misaligned = 1'b0;
    endcase
  end
  assign core_misalign_o = (state == RESP) && mis_q;
`else
  assign req_misaligned  = 1'b0;
  assign core_misalign_o = 1'b0;
`endif

  // State register and request capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      size_q <= 3'd0;
      addr_q <= 32'd0;
      wd_q   <= 32'd0;
      mis_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && core_req_i) begin
        we_q   <= core_we_i;
        size_q <= core_size_i;
        addr_q <= core_addr_i;
        wd_q   <= core_wd_i;
        mis_q  <= req_misaligned;
      end
    end
  end

  // Lane steering from the latched request
  always_comb begin
    case (size_width(size_q))
      WIDTH_BYTE: begin
        be     = 4'b0001 << addr_q[1:0];
        wd_rep = {4{wd_q[7:0]}};
      end
      WIDTH_HALF: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{wd_q[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wd_rep = wd_q;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .mem_rd_i (mem_rd_i),
    .addr     (addr_q[1:0]),
    .size     (size_q),
    .data     (load_data)
  );

  // Next-state and outputs
  always_comb begin
    state_next   = state;
    core_stall_o = 1'b0;
    core_rd_o    = 32'd0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'd0;
    mem_addr_o   = 32'd0;
    mem_wd_o     = 32'd0;
    case (state)
      IDLE: begin
        // Stall is raised in the request cycle itself so the core holds.
        core_stall_o = core_req_i;
        if (core_req_i) begin
          state_next = req_misaligned ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        core_stall_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_we_o     = we_q;
        mem_be_o     = be;
        mem_addr_o   = {addr_q[31:2], 2'b00};
        mem_wd_o     = wd_rep;
        if (mem_ready_i) begin
          state_next = RESP;
        end
      end
      RESP: begin
        // Loads keep the request up for the data phase of the memory.
        if (!we_q && !mis_q) begin
          mem_req_o  = 1'b1;
          mem_be_o   = be;
          mem_addr_o = {addr_q[31:2], 2'b00};
          mem_wd_o   = wd_rep;
          core_rd_o  = load_data;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_lsu.sv
//------------------------------------------------------------------------------
// tb_riscv_lsu
// Self-checking bench for riscv_lsu: a table of directed accesses, hand
// sequences for reset abort and misaligned words, and random accesses
// compared against an arithmetic reference model.
// Optional feature: LSU_MISALIGN_TRAP_EN selects the trapping expectations.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o, core_misalign_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  riscv_lsu dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .core_req_i     (core_req_i),
    .core_we_i      (core_we_i),
    .core_size_i    (core_size_i),
    .core_addr_i    (core_addr_i),
    .core_wd_i      (core_wd_i),
    .core_rd_o      (core_rd_o),
    .core_stall_o   (core_stall_o),
    .core_misalign_o(core_misalign_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wd_o       (mem_wd_o),
    .mem_rd_i       (mem_rd_i),
    .mem_ready_i    (mem_ready_i)
  );

  typedef struct {
    bit        we;
    bit [2:0]  size;
    bit [31:0] addr;
    bit [31:0] wd;
    bit [31:0] mem;
    int        delay;
    bit [3:0]  be;
    bit [31:0] ewd;
    bit [31:0] erd;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h expected %h", nm, what, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int width_of(input bit [2:0] size);
    if (size == 3'd0 || size == 3'd4) return 1;
    if (size == 3'd1 || size == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit [3:0] model_be(input bit [2:0] size, input bit [31:0] addr);
    int w = width_of(size);
    if (w == 1) return 4'(1 << (addr % 4));
    if (w == 2) return 4'(3 << (addr & 2));
    return 4'hF;
  endfunction

  function automatic bit [31:0] model_wd(input bit [2:0] size, input bit [31:0] wd);
    int w = width_of(size);
    if (w == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (w == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic bit [31:0] model_rd(input bit [2:0] size, input bit [31:0] addr,
                                         input bit [31:0] mem);
    int w = width_of(size);
    bit [31:0] v;
    if (w == 1) begin
      v = (mem >> (8 * (addr % 4))) & 32'hFF;
      if (size == 3'd0 && v >= 128) v = v - 256;
      return v;
    end
    if (w == 2) begin
      v = (mem >> (8 * (addr & 2))) & 32'hFFFF;
      if (size == 3'd1 && v >= 32768) v = v - 65536;
      return v;
    end
    return mem;
  endfunction

  function automatic bit model_trap(input bit [2:0] size, input bit [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    int w = width_of(size);
    return (w == 2 && (addr % 2) != 0) || (w == 4 && (addr % 4) != 0);
`else
    return (size == 3'd7) && (addr == 32'd1) && 1'b0;
`endif
  endfunction

  // One complete access; starts and ends one time unit after a rising edge.
  task automatic run_access(input string nm, input bit we, input bit [2:0] size,
                            input bit [31:0] addr, input bit [31:0] wd,
                            input bit [31:0] mem, input int delay,
                            input bit [3:0] ebe, input bit [31:0] ewd,
                            input bit [31:0] erd, input bit etrap);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_ready_i = 1'b0;
    mem_rd_i    = $urandom;
    @(negedge clk_i);
    chk(nm, "idle_stall", core_stall_o, 1);
    chk(nm, "idle_memreq", mem_req_o, 0);
    @(posedge clk_i); #1;
    if (!etrap) begin
      for (int k = 0; k <= delay; k++) begin
        mem_ready_i = (k == delay);
        @(negedge clk_i);
        chk(nm, "acc_stall", core_stall_o, 1);
        chk(nm, "acc_req", mem_req_o, 1);
        chk(nm, "acc_we", mem_we_o, we);
        chk(nm, "acc_be", mem_be_o, ebe);
        chk(nm, "acc_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        if (we) chk(nm, "acc_wd", mem_wd_o, ewd);
        @(posedge clk_i); #1;
      end
      mem_ready_i = 1'b0;
    end else begin
      chk(nm, "trap_noreq", mem_req_o, 0);
    end
    mem_rd_i = mem;
    @(negedge clk_i);
    chk(nm, "resp_stall", core_stall_o, 0);
    chk(nm, "resp_mis", core_misalign_o, etrap);
    chk(nm, "resp_req", mem_req_o, !we && !etrap);
    if (!we && !etrap) begin
      chk(nm, "resp_we", mem_we_o, 0);
      chk(nm, "resp_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
    end
    chk(nm, "resp_rd", core_rd_o, erd);
    core_req_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk(nm, "post_req", mem_req_o, 0);
    chk(nm, "post_stall", core_stall_o, 0);
    chk(nm, "post_rd", core_rd_o, 0);
    chk(nm, "post_mis", core_misalign_o, 0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    bit        we, trap;
    bit [2:0]  size;
    bit [31:0] addr, wd, mem;
    int        delay;

    // we size addr wd mem delay be ewd erd
    tbl[0]  = '{1'b1, 3'd2, 32'h104, 32'hCAFE_BABE, 32'h0,         0, 4'b1111, 32'hCAFE_BABE, 32'h0};
    tbl[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,         32'h8012_3456, 0, 4'b1000, 32'h0, 32'hFFFF_FF80};
    tbl[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,         32'h8012_3456, 1, 4'b1000, 32'h0, 32'h0000_0080};
    tbl[3]  = '{1'b1, 3'd1, 32'h22,  32'h0000_BEEF, 32'h0,         0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    tbl[4]  = '{1'b0, 3'd2, 32'h200, 32'h0,         32'h1234_5678, 3, 4'b1111, 32'h0, 32'h1234_5678};
    tbl[5]  = '{1'b0, 3'd1, 32'h12,  32'h0,         32'h8001_7FFF, 0, 4'b1100, 32'h0, 32'hFFFF_8001};
    tbl[6]  = '{1'b0, 3'd5, 32'h10,  32'h0,         32'h8001_F00D, 2, 4'b0011, 32'h0, 32'h0000_F00D};
    tbl[7]  = '{1'b1, 3'd0, 32'h41,  32'h1234_56A5, 32'h0,         1, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    tbl[8]  = '{1'b0, 3'd3, 32'h80,  32'h0,         32'hDEAD_BEEF, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF};
    tbl[9]  = '{1'b1, 3'd6, 32'h84,  32'h1122_3344, 32'h0,         0, 4'b1111, 32'h1122_3344, 32'h0};
    tbl[10] = '{1'b0, 3'd0, 32'h300, 32'h0,         32'h0000_007F, 0, 4'b0001, 32'h0, 32'h0000_007F};
    tbl[11] = '{1'b0, 3'd7, 32'h8,   32'h0,         32'hA5A5_A5A5, 0, 4'b1111, 32'h0, 32'hA5A5_A5A5};

    rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
    core_addr_i = 32'd0; core_wd_i = 32'd0; mem_rd_i = 32'd0; mem_ready_i = 1'b0;

    // Reset state
    #2;
    chk("reset", "mem_req", mem_req_o, 0);
    chk("reset", "mem_be", mem_be_o, 0);
    chk("reset", "core_rd", core_rd_o, 0);
    chk("reset", "stall_lo", core_stall_o, 0);
    core_req_i = 1'b1; #1;
    chk("reset", "stall_follows", core_stall_o, 1);
    core_req_i = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    foreach (tbl[i])
      run_access($sformatf("tbl%0d", i), tbl[i].we, tbl[i].size, tbl[i].addr,
                 tbl[i].wd, tbl[i].mem, tbl[i].delay, tbl[i].be, tbl[i].ewd,
                 tbl[i].erd, 1'b0);

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    run_access("lw_mis", 1'b0, 3'd2, 32'h102, 32'h0, 32'hAABB_CCDD, 0,
               4'b1111, 32'h0, 32'h0, 1'b1);
`else
    run_access("lw_mis", 1'b0, 3'd2, 32'h102, 32'h0, 32'hAABB_CCDD, 0,
               4'b1111, 32'h0, 32'hAABB_CCDD, 1'b0);
`endif

    // Reset pulse while a store waits in ACCESS
    core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
    core_addr_i = 32'h500; core_wd_i = 32'h5555_AAAA; mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rst_abort", "in_access", mem_req_o, 1);
    #1 rst_i = 1'b1;
    #1;
    chk("rst_abort", "req_drop", mem_req_o, 0);
    chk("rst_abort", "we_drop", mem_we_o, 0);
    chk("rst_abort", "stall_follows", core_stall_o, 1);
    core_req_i = 1'b0; mem_ready_i = 1'b1; #1;
    chk("rst_abort", "stall_lo", core_stall_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rst_abort", "no_retry", mem_req_o, 0);
    chk("rst_abort", "idle_stall", core_stall_o, 0);
    mem_ready_i = 1'b0;
    @(posedge clk_i); #1;

    // Random accesses against the model
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom % 2);
      if (we) size = 3'(($urandom % 4 == 0) ? 3 + 3 * ($urandom % 2) : $urandom % 3);
      else begin
        case ($urandom % 8)
          0: size = 3'd0; 1: size = 3'd1; 2: size = 3'd2; 3: size = 3'd4;
          4: size = 3'd5; 5: size = 3'd7; default: size = 3'(($urandom % 2) ? 3 : 6);
        endcase
      end
      addr = $urandom;
      if ($urandom % 2) addr = addr & ~(32'(width_of(size)) - 1);
      wd    = $urandom;
      mem   = $urandom;
      delay = int'($urandom % 3);
      trap  = model_trap(size, addr);
      run_access($sformatf("rnd%0d", n), we, size, addr, wd, mem, delay,
                 model_be(size, addr), model_wd(size, wd),
                 (we || trap) ? 32'h0 : model_rd(size, addr, mem), trap);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_i  input  1  reset; asynchronous, active-high.
REQ-003 core_req_i  input  1  core requests a load/store this cycle.
REQ-004 core_we_i  input  1  1 = store, 0 = load.
REQ-005 core_size_i  input  3  funct3 encoding: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-006 core_addr_i  input  32  byte address.
REQ-007 core_wd_i  input  32  store data, LSB-aligned.
REQ-008 core_rd_o  output  32  extended load result.
REQ-009 core_stall_o  output  1  core must hold its request while high.
REQ-010 core_misalign_o  output  1  misaligned-access flag.
REQ-011 mem_req_o  output  1  memory request.
REQ-012 mem_we_o  output  1  memory write enable.
REQ-013 mem_be_o  output  4  byte enables.
REQ-014 mem_addr_o  output  32  word-aligned address; bits [1:0] are 0.
REQ-015 mem_wd_o  output  32  lane-replicated write data.
REQ-016 mem_rd_i  input  32  memory read data; valid while mem_req_i is high in the cycle after acceptance.
REQ-017 mem_ready_i  input  1  memory accepts the current request.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP.
REQ-019 IDLE with core_req_i=1: latch we/size/addr/wd, assert core_stall_o combinationally, go to ACCESS.
REQ-020 ACCESS: drive mem_req_o=1 with latched fields and keep core_stall_o=1; on mem_ready_i=1 go to RESP, otherwise stay.
REQ-021 RESP, one cycle: core_stall_o=0.
REQ-022 RESP for a load: keep mem_req_o=1 with mem_we_o=0 and the same address, and drive core_rd_o from mem_rd_i.
REQ-023 RESP for a store: mem_req_o=0 and core_rd_o=0.
REQ-024 After RESP the FSM always goes to IDLE; back-to-back requests therefore cost 3 cycles each.
REQ-025 Byte enables: B gives 4'b0001<<addr[1:0]; H gives 4'b0011<<{addr[1],1'b0}; W gives 4'b1111.
REQ-026 Store data: B gives {4{wd[7:0]}}; H gives {2{wd[15:0]}}; W gives wd.
REQ-027 Load extraction: B/BU select the byte at addr[1:0]; H/HU select the half at addr[1].
REQ-028 Load extension: B and H sign-extend; BU and HU zero-extend; W passes through.
REQ-029 Undefined sizes 3, 6, 7 are treated as W.
REQ-030 Outside ACCESS/RESP, all mem_* outputs are 0 and core_rd_o is 0.
REQ-031 mem_ready_i=0 held indefinitely keeps the FSM in ACCESS with all outputs stable.

Reset
REQ-032 rst_i=1 immediately forces IDLE and clears latched fields; all outputs go to 0, except core_stall_o, which follows core_req_i.
REQ-033 Reset during ACCESS or RESP aborts the transfer and drops mem_req_o in the same cycle; no retry.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN.
REQ-035 With LSU_MISALIGN_TRAP_EN defined:
- A request is misaligned when it is H/HU with addr[0]=1, or W with addr[1:0]≠0.
- A misaligned request goes IDLE→RESP without entering ACCESS, and mem_req_o stays 0.
- In that RESP, core_misalign_o=1 and core_rd_o=0.
REQ-036 Without LSU_MISALIGN_TRAP_EN, core_misalign_o is tied 0 and misaligned requests follow REQ-025..028 with the offending low address bits ignored.

Structure
REQ-037 Package riscv_lsu_pkg holds:
- the size encodings LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU;
- the lsu_state_t enum.
REQ-038 Sub-module lsu_load_align (combinational; inputs mem_rd_i, addr[1:0], size; output extended data) contains REQ-027..029.

Verification
REQ-039 SW addr 0x104, wd 0xCAFEBABE, ready=1:
- ACCESS: mem_be_o=1111, mem_addr_o=0x104, mem_wd_o=0xCAFEBABE.
- core_stall_o drops in the third cycle.
REQ-040 LB addr 0x103, memory word 0x80123456: core_rd_o=0xFFFFFF80; LBU at the same address gives 0x00000080.
REQ-041 SH addr 0x22, wd 0x0000BEEF: mem_be_o=1100, mem_wd_o=0xBEEFBEEF, mem_addr_o=0x20.
REQ-042 LW with mem_ready_i low for 3 cycles: FSM stays in ACCESS 4 cycles, core_stall_o high throughout, then RESP delivers the word.
REQ-043 rst_i pulse during ACCESS: mem_req_o=0 within the same cycle, FSM in IDLE, no write performed.
REQ-044 With LSU_MISALIGN_TRAP_EN, LW addr 0x102: mem_req_o never rises and core_misalign_o=1 for one cycle; without the macro, the same access reads word 0x100.
